// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and time limits.
package timer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEC_MAX = 59;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COUNT = 3'd2,
    ST_PAUSE = 3'd3,
    ST_CLEAR = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// Holds its count while disabled; synchronous clear has priority over enable.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  // Count 0..TICK_DIV-1 while enabled, wrapping on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer: button edge detection, control FSM, time registers
// and tick prescaler. Define TIMER_AUTO_RELOAD_EN to make start in DONE
// reload the last started preset and resume counting.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MIN_W    = 7,
  parameter int unsigned MAX_MIN  = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             inc_sec,
  input  logic             inc_min,
  output logic [5:0]       sec,
  output logic [MIN_W-1:0] min,
  output logic [2:0]       state,
  output logic             running,
  output logic             finished,
  output logic             done_pulse
);

  localparam logic [5:0]       SEC_LAST = 6'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

  state_t           state_q, state_d;
  logic [5:0]       sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic             done_q, done_d;

  logic [4:0] btn, btn_q, rise;
  logic       clr_rise, start_rise, stop_rise, isec_rise, imin_rise;

  logic             tick;
  logic             time_zero, dec_zero;
  logic [5:0]       sec_inc, sec_dec;
  logic [MIN_W-1:0] min_inc, min_dec;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [5:0]       preset_sec;
  logic [MIN_W-1:0] preset_min;
  logic             preset_load;
`endif

  assign btn        = {clear, start, stop, inc_sec, inc_min};
  assign rise       = btn & ~btn_q;
  assign clr_rise   = rise[4];
  assign start_rise = rise[3];
  assign stop_rise  = rise[2];
  assign isec_rise  = rise[1];
  assign imin_rise  = rise[0];

  // One-cycle history of the debounced buttons for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= '0;
    else        btn_q <= btn;
  end

  // Prescaler runs only in COUNT, holds in PAUSE, and is zeroed everywhere else
  // so that every entry into COUNT from SET or DONE starts a full second.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == ST_COUNT),
    .clr  (!(state_q == ST_COUNT || state_q == ST_PAUSE)),
    .tick (tick)
  );

  assign time_zero = (sec_q == '0) && (min_q == '0);
  assign dec_zero  = (sec_q == 6'd1) && (min_q == '0);
  assign sec_inc   = (sec_q == SEC_LAST) ? '0 : sec_q + 6'd1;
  assign min_inc   = (min_q == MIN_LAST) ? '0 : min_q + 1'b1;
  assign sec_dec   = (sec_q != '0) ? sec_q - 6'd1 : SEC_LAST;
  assign min_dec   = (sec_q != '0) ? min_q : min_q - 1'b1;

  // Next-state and time update; clear overrides every other event.
  // Reaching 00:00 stays in COUNT for one cycle and moves to DONE on the next,
  // which is why a stop on the final tick is dropped rather than pausing.
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    done_d  = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    preset_load = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (isec_rise) begin
          state_d = ST_SET;
          sec_d   = sec_inc;
        end else if (imin_rise) begin
          state_d = ST_SET;
          min_d   = min_inc;
        end
      end
      ST_SET: begin
        if (start_rise) begin
          if (!time_zero) begin
            state_d = ST_COUNT;
`ifdef TIMER_AUTO_RELOAD_EN
            preset_load = 1'b1;
`endif
          end
        end else if (isec_rise) begin
          sec_d = sec_inc;
        end else if (imin_rise) begin
          min_d = min_inc;
        end
      end
      ST_COUNT: begin
        if (time_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (tick) begin
          sec_d = sec_dec;
          min_d = min_dec;
          if (stop_rise && !dec_zero) state_d = ST_PAUSE;
        end else if (stop_rise) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_rise) state_d = ST_COUNT;
      end
      ST_DONE: begin
        if (start_rise) begin
`ifdef TIMER_AUTO_RELOAD_EN
          state_d = ST_COUNT;
          sec_d   = preset_sec;
          min_d   = preset_min;
`else
          state_d = ST_IDLE;
          sec_d   = '0;
          min_d   = '0;
`endif
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
        sec_d   = '0;
        min_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        sec_d   = '0;
        min_d   = '0;
      end
    endcase

    if (clr_rise) begin
      state_d = ST_CLEAR;
      sec_d   = '0;
      min_d   = '0;
      done_d  = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      preset_load = 1'b0;
`endif
    end
  end

  // State, time and done-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sec_q   <= '0;
      min_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      done_q  <= done_d;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  // Latch the time that was started from SET for reload on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preset_sec <= '0;
      preset_min <= '0;
    end else if (preset_load) begin
      preset_sec <= sec_q;
      preset_min <= min_q;
    end
  end
`endif

  assign sec        = sec_q;
  assign min        = min_q;
  assign state      = state_q;
  assign running    = (state_q == ST_COUNT);
  assign finished   = (state_q == ST_DONE);
  assign done_pulse = done_q;

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
Parametrised countdown timer: control FSM plus time registers and a tick prescaler in one block. Replaces the separate state machine + external counter pairing. Operator sets MM:SS with increment buttons, then starts, pauses, clears and acknowledges expiry. Outputs feed the VGA digit renderer and status indicators.

Parameters:
TICK_DIV, 50_000_000, clk cycles per 1 s tick (≥2)
MIN_W, 7, minute register width
MAX_MIN, 99, highest settable minute value (≤ 2^MIN_W−1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level, debounced; rising edge used
stop  in  1  level, debounced; rising edge used
clear  in  1  level, debounced; rising edge used
inc_sec  in  1  level, debounced; rising edge used
inc_min  in  1  level, debounced; rising edge used
sec  out  6  current seconds 0..59
min  out  MIN_W  current minutes 0..MAX_MIN
state  out  3  IDLE=0 SET=1 COUNT=2 PAUSE=3 CLEAR=4 DONE=5
running  out  1  high in COUNT
finished  out  1  high in DONE
done_pulse  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sec=0, min=0, prescaler=0, edge-detect history=0, all 1-bit outputs 0.
- All button inputs are edge-detected internally (1-cycle registered history). Only the first cycle of each press acts.
- Event priority in every state: clear > start > stop > inc_sec > inc_min.
- IDLE: inc_sec/inc_min → SET, with the increment applied in the same cycle. start/stop ignored.
- SET:
  - inc_sec: sec+1, 59→0, no carry into min.
  - inc_min: min+1, MAX_MIN→0.
  - start with time≠00:00 → COUNT, prescaler=0, preset latched.
  - start with 00:00 → ignored.
- COUNT:
  - Prescaler counts 0..TICK_DIV−1. Tick on wrap.
  - Tick decrement: sec>0 → sec−1; else min−1 and sec=59.
  - Tick that makes time 00:00 → DONE next cycle, done_pulse=1 for that one cycle.
  - stop → PAUSE.
- PAUSE: prescaler and time frozen; start → COUNT, prescaler resumes from its held value.
- CLEAR, entered from any state on clear: lasts 1 cycle; sec=min=prescaler=0 → IDLE.
- DONE: time held at 00:00, finished=1; start → IDLE. inc/stop ignored.
- Simultaneous events:
  - clear+start same cycle → CLEAR.
  - Tick and stop same cycle in COUNT → decrement applied, then PAUSE.
  - Tick reaching zero and stop same cycle → DONE wins.
- Undefined state codes 6,7 → IDLE next cycle, time cleared.
- running/finished are decoded from registered state; no combinational path from inputs to outputs.

Optional Feature:
Macro TIMER_AUTO_RELOAD_EN.
- Defined: in DONE, start reloads the latched preset into min/sec and goes directly to COUNT with prescaler=0. clear still → CLEAR.
- Undefined: DONE + start → IDLE with 00:00, and the preset register is not synthesised.

Decomposition:
- Shared package timer_pkg: state localparams (IDLE..DONE, 3-bit), SEC_MAX=59, state type width.
- One natural sub-module, tick_prescaler: counter with enable, sync clear and tick output, parameter TICK_DIV.
- FSM, edge detection and time registers stay in countdown_timer_ctrl.

Test Plan:
All scenarios use TICK_DIV=4.
1. Reset mid-COUNT at 01:30 → all outputs 0 and state=IDLE immediately, without waiting for a clk edge.
2. 3×inc_sec, 2×inc_min from IDLE → SET, 02:03. 60×inc_sec → sec wraps back to 3, min stays 2.
3. Set 00:02, start → sec=1 after 4 cycles, 00:00 after 8 cycles. DONE one cycle later, done_pulse exactly 1 cycle, finished=1.
4. Counting 00:10, stop at prescaler=2, wait 20 cycles → time unchanged. start → next decrement after 2 more cycles.
5. start at 00:00 in SET → remains SET. clear+start same cycle in COUNT → CLEAR 1 cycle, then IDLE 00:00.
6. With TIMER_AUTO_RELOAD_EN: preset 00:03 expires, start → COUNT at 00:03. Without the macro: start → IDLE at 00:00.
